systolic_array_gen: RTL and testbench

Parametrised output-stationary N×N systolic matrix-multiply engine, the successor to the fixed 4×4 array. Computes C = A·B for an N×K by K×N operand pair streamed one K-slice per beat over a valid/ready handshake, with skewing done internally. Supports a runtime-selectable signed or unsigned mode. Results are returned as a row-by-row stream with backpressure. It sits between the CNN operand feeders and the result write-back path.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/systolic_pe.sv | 64 ++++++
 rtl/systolic_array_gen.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_array_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types, default sizes and width helpers for the parametrised
// output-stationary systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned N_DEF    = 32'd4;
  localparam int unsigned DW_DEF   = 32'd8;
  localparam int unsigned KMAX_DEF = 32'd256;

  function automatic int unsigned klen_w(input int unsigned kmax);
    return unsigned'($clog2(kmax + 32'd1));
  endfunction

  // A single-row array still needs a 1-bit row index port.
  function automatic int unsigned row_w(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned kmax);
    return 32'd2 * dw + unsigned'($clog2(kmax));
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Processing element: signed/unsigned multiply-accumulate with registered
// forwarding of the A operand rightwards and the B operand downwards.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned ACCW = acc_w(DW_DEF, KMAX_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            signed_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic [DW-1:0]   a_o,
  output logic [DW-1:0]   b_o,
  output logic [ACCW-1:0] acc_o
);

  logic signed [DW:0]     a_ext_s;
  logic signed [DW:0]     b_ext_s;
  logic signed [2*DW+1:0] prod_s;
  logic [ACCW-1:0]        acc_q, acc_d;
  logic [DW-1:0]          a_q, b_q;

  // One extra operand bit lets a single signed multiplier serve both modes.
  always_comb begin
    if (signed_i) begin
      a_ext_s = {a_i[DW-1], a_i};
      b_ext_s = {b_i[DW-1], b_i};
    end else begin
      a_ext_s = {1'b0, a_i};
      b_ext_s = {1'b0, b_i};
    end
    prod_s = a_ext_s * b_ext_s;
    if (clr_i) begin
      acc_d = {ACCW{1'b0}};
    end else begin
      acc_d = acc_q + ACCW'(prod_s);
    end
  end

  // Accumulator and forwarding registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= {ACCW{1'b0}};
      a_q   <= {DW{1'b0}};
      b_q   <= {DW{1'b0}};
    end else if (clr_i) begin
      acc_q <= acc_d;
      a_q   <= {DW{1'b0}};
      b_q   <= {DW{1'b0}};
    end else begin
      acc_q <= acc_d;
      a_q   <= a_i;
      b_q   <= b_i;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_gen.sv
// N x N output-stationary systolic matrix multiplier: skews streamed K-slices
// into a PE grid, then drains C row by row over a valid/ready handshake.
module systolic_array_gen
  import systolic_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned KMAX = KMAX_DEF,
  parameter int unsigned ACCW = acc_w(DW, KMAX)
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        start,
  input  logic [klen_w(KMAX)-1:0]     k_len,
  input  logic                        signed_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N*DW-1:0]             a_col,
  input  logic [N*DW-1:0]             b_row,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [row_w(N)-1:0]         out_row,
  output logic [N*ACCW-1:0]           out_data,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned KW = klen_w(KMAX);
  localparam int unsigned RW = row_w(N);
  localparam int unsigned FW = unsigned'($clog2(2 * N));
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_len_q, k_len_d, k_cnt_q, k_cnt_d;
  logic [FW-1:0]     fl_cnt_q, fl_cnt_d;
  logic [RW-1:0]     row_q, row_d, mux_sel_s;
  logic              mode_q, mode_d, clr_s, done_d;
  logic              in_ready_q, out_valid_q, busy_q, done_q;
  logic [N*ACCW-1:0] data_q, data_d, mux_data_s;
  logic              beat_s, hs_s;

  logic [DW-1:0]   a_sk_q  [N][N];
  logic [DW-1:0]   b_sk_q  [N][N];
  logic [DW-1:0]   a_fwd_s [N][N];
  logic [DW-1:0]   b_fwd_s [N][N];
  logic [ACCW-1:0] acc_s   [N][N];

  assign beat_s = in_valid & in_ready_q;
  assign hs_s   = out_valid_q & out_ready;

  // Skew triangles: stage 0 takes the beat (zero on a bubble); lane i taps stage i.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N; s++) begin
          a_sk_q[i][s] <= {DW{1'b0}};
          b_sk_q[i][s] <= {DW{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_sk_q[i][0] <= beat_s ? a_col[i*DW +: DW] : {DW{1'b0}};
        b_sk_q[i][0] <= beat_s ? b_row[i*DW +: DW] : {DW{1'b0}};
        for (int s = 1; s < N; s++) begin
          a_sk_q[i][s] <= a_sk_q[i][s-1];
          b_sk_q[i][s] <= b_sk_q[i][s-1];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] a_in_s, b_in_s;
      if (gj == 0) begin : g_a_edge
        assign a_in_s = a_sk_q[gi][gi];
      end else begin : g_a_fwd
        assign a_in_s = a_fwd_s[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in_s = b_sk_q[gj][gj];
      end else begin : g_b_fwd
        assign b_in_s = b_fwd_s[gi-1][gj];
      end
      systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk_i    (CLK),
        .rst_ni   (RSTn),
        .clr_i    (clr_s),
        .signed_i (mode_q),
        .a_i      (a_in_s),
        .b_i      (b_in_s),
        .a_o      (a_fwd_s[gi][gj]),
        .b_o      (b_fwd_s[gi][gj]),
        .acc_o    (acc_s[gi][gj])
      );
    end
  end

  // Row mux: row 0 when leaving FLUSH, otherwise the row after the one shown.
  always_comb begin
    mux_data_s = {(N*ACCW){1'b0}};
    if (state_q == ST_DRAIN) begin
      mux_sel_s = row_q + RW'(1);
    end else begin
      mux_sel_s = {RW{1'b0}};
    end
    for (int j = 0; j < N; j++) begin
      mux_data_s[j*ACCW +: ACCW] = acc_s[mux_sel_s][j];
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    k_cnt_d  = k_cnt_q;
    fl_cnt_d = fl_cnt_q;
    row_d    = row_q;
    mode_d   = mode_q;
    data_d   = data_q;
    clr_s    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr_s    = 1'b1;
          k_len_d  = k_len;
          mode_d   = signed_mode;
          k_cnt_d  = {KW{1'b0}};
          fl_cnt_d = {FW{1'b0}};
          row_d    = {RW{1'b0}};
          if (k_len == {KW{1'b0}}) begin
            state_d = ST_DRAIN;
            data_d  = {(N*ACCW){1'b0}};
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (beat_s && (k_cnt_q == k_len_q - KW'(1))) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = {FW{1'b0}};
        end else if (beat_s) begin
          k_cnt_d = k_cnt_q + KW'(1);
        end else begin
          k_cnt_d = k_cnt_q;
        end
      end
      ST_FLUSH: begin
        if (fl_cnt_q == FLUSH_LAST) begin
          state_d = ST_DRAIN;
          data_d  = mux_data_s;
        end else begin
          fl_cnt_d = fl_cnt_q + FW'(1);
        end
      end
      ST_DRAIN: begin
        if (hs_s && (row_q == ROW_LAST)) begin
          state_d = ST_IDLE;
          row_d   = {RW{1'b0}};
          done_d  = 1'b1;
        end else if (hs_s) begin
          row_d  = row_q + RW'(1);
          data_d = mux_data_s;
        end else begin
          row_d = row_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      k_len_q     <= {KW{1'b0}};
      k_cnt_q     <= {KW{1'b0}};
      fl_cnt_q    <= {FW{1'b0}};
      row_q       <= {RW{1'b0}};
      mode_q      <= 1'b0;
      data_q      <= {(N*ACCW){1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      fl_cnt_q    <= fl_cnt_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      in_ready_q  <= (state_d == ST_LOAD);
      out_valid_q <= (state_d == ST_DRAIN);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = row_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_array_gen.sv
// Directed self-checking bench for systolic_array_gen at N=4, DW=8.
module tb_systolic_array_gen;

  localparam int N = 4, DW = 8, KMAX = 256, ACCW = 24, KW = 9, RW = 2;

  logic CLK = 1'b0, RSTn = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] a_col = '0, b_row = '0;
  logic in_ready, out_valid, busy, done;
  logic [RW-1:0] out_row;
  logic [N*ACCW-1:0] out_data;

  int n_checks = 0, n_errors = 0, cyc = 0, done_cnt = 0;

  logic [DW-1:0]     ma [N][KMAX];
  logic [DW-1:0]     mb [KMAX][N];
  logic [N*ACCW-1:0] exp_rows [N];
  logic [N*ACCW-1:0] got_rows [N];

  systolic_array_gen #(.N(N), .DW(DW), .KMAX(KMAX), .ACCW(ACCW)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    done_cnt <= done_cnt + int'(done);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_model(input int k, input bit sm);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          int av, bv;
          av = sm ? int'($signed(ma[i][kk])) : int'(ma[i][kk]);
          bv = sm ? int'($signed(mb[kk][j])) : int'(mb[kk][j]);
          s += av * bv;
        end
        exp_rows[i][j*ACCW +: ACCW] = ACCW'(s);
      end
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++) begin
      for (int kk = 0; kk < N; kk++) begin
        ma[i][kk] = DW'(5 * i + kk + 1);
        mb[kk][i] = (kk == i) ? 8'd1 : 8'd0;
      end
    end
  endtask

  task automatic run_job(input int k, input bit sm, input bit bubbles, input int stall,
                         input bit poke, input string tag);
    int s_cyc, last_b, first_o, idx, g, base;
    build_model(k, sm);
    base = done_cnt;
    @(negedge CLK);
    start = 1'b1; k_len = KW'(k); signed_mode = sm; s_cyc = cyc;
    @(negedge CLK);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    if (k > 0) begin
      chk({tag, "_inrdy"}, in_ready, 1);
      idx = 0; g = 0; last_b = 0;
      while (idx < k && g < 4 * k + 10) begin
        in_valid = !(bubbles && (g % 2 == 1));
        for (int i = 0; i < N; i++) begin
          a_col[i*DW +: DW] = ma[i][idx];
          b_row[i*DW +: DW] = mb[idx][i];
        end
        if (poke && g == 2) begin start = 1'b1; k_len = KW'(1); end
        else begin start = 1'b0; k_len = KW'(k); end
        if (in_valid && in_ready) begin last_b = cyc; idx++; end
        @(negedge CLK);
        g++;
      end
      in_valid = 1'b0; start = 1'b0;
      chk({tag, "_beats"}, idx, k);
      chk({tag, "_flush_rdy"}, in_ready, 0);
      g = 0;
      while (!out_valid && g < 100) begin @(negedge CLK); g++; end
      first_o = cyc;
      chk({tag, "_lat"}, first_o - last_b, 2 * N);
      if (!bubbles) chk({tag, "_joblat"}, first_o - s_cyc, 1 + k + 2 * N - 1);
    end else begin
      chk({tag, "_ov0"}, out_valid, 1);
    end
    for (int r = 0; r < N; r++) begin
      out_ready = 1'b0;
      for (int st = 0; st < stall; st++) begin
        @(negedge CLK);
        chk({tag, "_hold_v"}, out_valid, 1);
        chk({tag, "_hold_row"}, out_row, r);
        chk({tag, "_hold_data"}, out_data, exp_rows[r]);
      end
      out_ready = 1'b1;
      chk({tag, "_v"}, out_valid, 1);
      chk({tag, "_row"}, out_row, r);
      chk({tag, "_data"}, out_data, exp_rows[r]);
      got_rows[r] = out_data;
      @(negedge CLK);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_ov_off"}, out_valid, 0);
    out_ready = 1'b0;
    @(negedge CLK);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_done_cnt"}, done_cnt - base, 1);
  endtask

  initial begin
    int base;
    #2;
    chk("rst_inrdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_row", out_row, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge CLK); RSTn = 1'b1;
    @(negedge CLK);

    set_identity();
    run_job(4, 1'b0, 1'b0, 0, 1'b0, "ident");
    chk("ident_r0", got_rows[0], {24'd4, 24'd3, 24'd2, 24'd1});
    chk("ident_r3", got_rows[3], {24'd19, 24'd18, 24'd17, 24'd16});

    run_job(4, 1'b0, 1'b1, 0, 1'b0, "bub");
    chk("bub_r2", got_rows[2], {24'd14, 24'd13, 24'd12, 24'd11});

    for (int i = 0; i < N; i++) begin
      for (int kk = 0; kk < N; kk++) begin
        ma[i][kk] = 8'h80;
        mb[kk][i] = 8'h7F;
      end
    end
    run_job(4, 1'b1, 1'b0, 0, 1'b0, "sgn");
    chk("sgn_r1", got_rows[1], {4{24'hFF0200}});
    run_job(4, 1'b0, 1'b0, 0, 1'b0, "uns");
    chk("uns_r3", got_rows[3], {4{24'h00FE00}});

    set_identity();
    run_job(4, 1'b0, 1'b0, 3, 1'b0, "bp");
    run_job(4, 1'b0, 1'b0, 0, 1'b1, "poke");
    chk("poke_r1", got_rows[1], {24'd9, 24'd8, 24'd7, 24'd6});
    run_job(0, 1'b0, 1'b0, 0, 1'b0, "k0");
    chk("k0_r0", got_rows[0], 96'd0);

    // Abandon a job partway through FLUSH.
    @(negedge CLK); start = 1'b1; k_len = KW'(4); signed_mode = 1'b0;
    @(negedge CLK); start = 1'b0; in_valid = 1'b1;
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = ma[i][kk];
        b_row[i*DW +: DW] = mb[kk][i];
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rstf_busy_pre", busy, 1);
    base = done_cnt;
    RSTn = 1'b0;
    #1;
    chk("rstf_inrdy", in_ready, 0);
    chk("rstf_ov", out_valid, 0);
    chk("rstf_row", out_row, 0);
    chk("rstf_data", out_data, 0);
    chk("rstf_busy", busy, 0);
    chk("rstf_done", done, 0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
    chk("rstf_nodone", done_cnt - base, 0);
    chk("rstf_idle", busy, 0);
    run_job(4, 1'b0, 1'b0, 0, 1'b0, "post_rst");
    chk("post_rst_r2", got_rows[2], {24'd14, 24'd13, 24'd12, 24'd11});

    for (int kk = 0; kk < 40; kk++) begin
      for (int i = 0; i < N; i++) begin
        ma[i][kk] = DW'($urandom_range(0, 255));
        mb[kk][i] = DW'($urandom_range(0, 255));
      end
    end
    run_job(40, 1'b1, 1'b1, 1, 1'b0, "rnd_s");
    run_job(40, 1'b0, 1'b0, 2, 1'b0, "rnd_u");

    for (int kk = 0; kk < KMAX; kk++) begin
      for (int i = 0; i < N; i++) begin
        ma[i][kk] = 8'hFF;
        mb[kk][i] = 8'hFF;
      end
    end
    run_job(KMAX, 1'b0, 1'b0, 0, 1'b0, "kmax");
    chk("kmax_r0", got_rows[0], {4{24'hFE0100}});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
